// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-add multiplier, signed/unsigned WIDTH x WIDTH -> 2*WIDTH, with cancel
module seq_mul_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               sign_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] z_o
);
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mc_q, mc_d, acc_q, acc_d, z_q, z_d, digit;
  logic [WIDTH-1:0] b_q, b_d, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, done_q, done_d, load, calc, last;
  assign load  = (state_q == IDLE) & start_i & ~cancel_i;
  assign calc  = state_q == CALC;
  assign last  = cnt_q == CW'(N - 1);
  assign a_mag = (sign_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (sign_i & b_i[WIDTH-1]) ? -b_i : b_i;
  assign digit = {{(2*WIDTH-RADIX_BITS){1'b0}}, b_q[RADIX_BITS-1:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = cancel_i                  ? IDLE :
              load                      ? CALC :
              (calc & last)             ? FIX  :
              (state_q == FIX)          ? IDLE : state_q;
  end
  always_comb begin
    busy_o = state_q != IDLE;
    done_d = (state_q == FIX) & ~cancel_i;
    z_d    = done_d ? (neg_q ? -acc_q : acc_q) : z_q;
  end
  // The multiplicand is pre-shifted each step, so the partial product lands at counter*RADIX_BITS.
  always_comb begin
    mc_d  = load ? {{WIDTH{1'b0}}, a_mag} : calc ? mc_q << RADIX_BITS : mc_q;
    b_d   = load ? b_mag : calc ? b_q >> RADIX_BITS : b_q;
    acc_d = load ? '0 : calc ? acc_q + mc_q * digit : acc_q;
    cnt_d = load ? '0 : calc ? cnt_q + CW'(1) : cnt_q;
    neg_d = load ? sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : neg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q   <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      z_q    <= '0;
    end else begin
      mc_q   <= mc_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      done_q <= done_d;
      z_q    <= z_d;
    end
  end
  assign done_o = done_q;
  assign z_o    = z_q;
endmodule
